// File: rtl/arp_resolver_pkg.sv
// Shared types and constants for the ARP next-hop resolver.
package arp_resolver_pkg;

    localparam int unsigned IP_W  = 32;
    localparam int unsigned MAC_W = 48;

    localparam int unsigned DEFAULT_CACHE_ADDR_WIDTH    = 2;
    localparam int unsigned DEFAULT_REQUEST_TIMEOUT     = 1000;
    localparam int unsigned DEFAULT_REQUEST_RETRY_COUNT = 3;

    localparam logic [MAC_W-1:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [IP_W-1:0]  BROADCAST_IP  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_QUERY,
        ST_WAIT_REPLY,
        ST_RESPOND
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IP_W-1:0]  ip;
        logic [MAC_W-1:0] mac;
    } cache_entry_t;

endpackage

// File: rtl/arp_resolver_cache.sv
// Direct-mapped IP->MAC cache: one write port, bulk clear, and a
// combinational read port that sees a same-cycle write.
module arp_resolver_cache
    import arp_resolver_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_CACHE_ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [IP_W-1:0]  wr_ip,
    input  logic [MAC_W-1:0] wr_mac,
    input  logic [IP_W-1:0]  rd_ip,
    output logic             hit_c,
    output logic [MAC_W-1:0] rd_mac_c
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] valid;
    logic [IP_W-1:0]  ip_mem  [DEPTH];
    logic [MAC_W-1:0] mac_mem [DEPTH];

    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    cache_entry_t      rd_entry;

    assign wr_idx = wr_ip[ADDR_W-1:0];
    assign rd_idx = rd_ip[ADDR_W-1:0];

    // Clear lands first; a write in the same cycle then leaves its entry valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ip_mem[ADDR_W'(i)]  <= '0;
                mac_mem[ADDR_W'(i)] <= '0;
            end
        end else begin
            if (clear) begin
                valid <= '0;
            end
            if (wr_en) begin
                valid[wr_idx]   <= 1'b1;
                ip_mem[wr_idx]  <= wr_ip;
                mac_mem[wr_idx] <= wr_mac;
            end
        end
    end

    always_comb begin
        rd_entry = '{valid: valid[rd_idx] & ~clear, ip: ip_mem[rd_idx], mac: mac_mem[rd_idx]};
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_entry = '{valid: 1'b1, ip: wr_ip, mac: wr_mac};
        end
    end

    assign hit_c    = rd_entry.valid && (rd_entry.ip == rd_ip);
    assign rd_mac_c = rd_entry.mac;

endmodule

// File: rtl/arp_resolver.sv
// Next-hop MAC resolver: classifies the destination, looks up the cache,
// and queries the ARP frame engine with timeout/retry on a miss.
module arp_resolver
    import arp_resolver_pkg::*;
#(
    parameter int unsigned CACHE_ADDR_WIDTH    = DEFAULT_CACHE_ADDR_WIDTH,
    parameter int unsigned REQUEST_TIMEOUT     = DEFAULT_REQUEST_TIMEOUT,
    parameter int unsigned REQUEST_RETRY_COUNT = DEFAULT_REQUEST_RETRY_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_arp_request_valid,
    output logic             s_arp_request_ready,
    input  logic [IP_W-1:0]  s_arp_request_ip,
    output logic             m_arp_response_valid,
    input  logic             m_arp_response_ready,
    output logic             m_arp_response_error,
    output logic [MAC_W-1:0] m_arp_response_mac,
    output logic             m_query_valid,
    input  logic             m_query_ready,
    output logic [IP_W-1:0]  m_query_ip,
    input  logic             s_reply_valid,
    input  logic [IP_W-1:0]  s_reply_ip,
    input  logic [MAC_W-1:0] s_reply_mac,
    input  logic             clear_cache,
    input  logic [IP_W-1:0]  local_ip,
    input  logic [IP_W-1:0]  gateway_ip,
    input  logic [IP_W-1:0]  subnet_mask,
    output logic             busy
);

    localparam int unsigned TIMER_W = $clog2(REQUEST_TIMEOUT + 1);
    localparam int unsigned RETRY_W = $clog2(REQUEST_RETRY_COUNT + 1);

    state_t state;
    state_t state_next;

    logic [IP_W-1:0]    req_ip;
    logic [IP_W-1:0]    next_hop;
    logic [IP_W-1:0]    lookup_hop;
    logic [MAC_W-1:0]   resp_mac;
    logic               resp_error;
    logic [TIMER_W-1:0] timer;
    logic [RETRY_W-1:0] retries;

    logic             on_subnet;
    logic             is_bcast;
    logic             no_gateway;
    logic             cache_hit;
    logic [MAC_W-1:0] cache_mac;
    logic             reply_match;

    arp_resolver_cache #(
        .ADDR_W (CACHE_ADDR_WIDTH)
    ) u_cache (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_cache),
        .wr_en    (s_reply_valid),
        .wr_ip    (s_reply_ip),
        .wr_mac   (s_reply_mac),
        .rd_ip    (lookup_hop),
        .hit_c    (cache_hit),
        .rd_mac_c (cache_mac)
    );

    // Destination classification; only consumed while in LOOKUP.
    always_comb begin
        on_subnet  = (req_ip & subnet_mask) == (local_ip & subnet_mask);
        is_bcast   = (req_ip == BROADCAST_IP) ||
                     (on_subnet && ((req_ip & ~subnet_mask) == ~subnet_mask));
        lookup_hop = on_subnet ? req_ip : gateway_ip;
        no_gateway = !on_subnet && (gateway_ip == '0);
    end

    assign reply_match = s_reply_valid && (s_reply_ip == next_hop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (s_arp_request_valid) state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (is_bcast || no_gateway || cache_hit) state_next = ST_RESPOND;
                else                                     state_next = ST_QUERY;
            end
            ST_QUERY: begin
                if (m_query_ready) state_next = ST_WAIT_REPLY;
            end
            ST_WAIT_REPLY: begin
                if (reply_match) begin
                    state_next = ST_RESPOND;
                end else if (timer == '0) begin
                    state_next = (retries != '0) ? ST_QUERY : ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (m_arp_response_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_arp_request_ready  = 1'b0;
        m_query_valid        = 1'b0;
        m_arp_response_valid = 1'b0;
        busy                 = 1'b1;
        case (state)
            ST_IDLE: begin
                s_arp_request_ready = 1'b1;
                busy                = 1'b0;
            end
            ST_QUERY:   m_query_valid        = 1'b1;
            ST_RESPOND: m_arp_response_valid = 1'b1;
            default: ;
        endcase
    end

    // Request/response registers, reply timer and retry counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ip     <= '0;
            next_hop   <= '0;
            resp_mac   <= '0;
            resp_error <= 1'b0;
            timer      <= '0;
            retries    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_arp_request_valid) req_ip <= s_arp_request_ip;
                end
                ST_LOOKUP: begin
                    next_hop   <= lookup_hop;
                    retries    <= RETRY_W'(REQUEST_RETRY_COUNT - 1);
                    resp_error <= !is_bcast && no_gateway;
                    if (is_bcast)                      resp_mac <= BROADCAST_MAC;
                    else if (!no_gateway && cache_hit) resp_mac <= cache_mac;
                    else                               resp_mac <= '0;
                end
                ST_QUERY: begin
                    if (m_query_ready) timer <= TIMER_W'(REQUEST_TIMEOUT - 1);
                end
                ST_WAIT_REPLY: begin
                    if (reply_match) begin
                        resp_mac   <= s_reply_mac;
                        resp_error <= 1'b0;
                    end else if (timer == '0) begin
                        if (retries != '0) begin
                            retries <= retries - RETRY_W'(1);
                        end else begin
                            resp_error <= 1'b1;
                            resp_mac   <= '0;
                        end
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_query_ip           = next_hop;
    assign m_arp_response_mac   = resp_mac;
    assign m_arp_response_error = resp_error;

endmodule
